// File: rtl/faerie_cu_hs.sv
// faerie_cu_hs: one-hot Faerie control unit with memory ready handshake, reset/IRQ vectors and bus timeout.
// Datapath strobes are decoded from the state and the current instruction byte.
module faerie_cu_hs #(
  parameter bit          IRQ_EN  = 1'b1,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rdata,
  input  logic       mem_ready,
  input  logic       irq,
  output logic [3:0] mode,
  output logic       we,
  output logic       re,
  output logic       pc_addr,
  output logic       zp_addr,
  output logic       set_al,
  output logic       set_ah,
  output logic       inc_al,
  output logic       reset_b,
  output logic       set_fr,
  output logic       set_a,
  output logic       branch,
  output logic       vec_load,
  output logic       vec_irq,
  output logic       irq_ack,
  output logic       bus_err,
  output logic [9:0] state
);
  localparam int I_RSTV = 0, I_FETCH = 1, I_ADDR1 = 2, I_ADDR2 = 3, I_PTR1 = 4;
  localparam int I_PTR2 = 5, I_MEMLD = 6, I_ALU = 7, I_MEMST = 8, I_IRQ = 9;
  localparam logic [9:0] S_RSTV  = 10'b1 << I_RSTV;
  localparam logic [9:0] S_FETCH = 10'b1 << I_FETCH;
  localparam logic [9:0] S_ADDR1 = 10'b1 << I_ADDR1;
  localparam logic [9:0] S_ADDR2 = 10'b1 << I_ADDR2;
  localparam logic [9:0] S_PTR1  = 10'b1 << I_PTR1;
  localparam logic [9:0] S_PTR2  = 10'b1 << I_PTR2;
  localparam logic [9:0] S_MEMLD = 10'b1 << I_MEMLD;
  localparam logic [9:0] S_ALU   = 10'b1 << I_ALU;
  localparam logic [9:0] S_MEMST = 10'b1 << I_MEMST;
  localparam logic [9:0] S_IRQ   = 10'b1 << I_IRQ;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [9:0] cur, nxt, exec_st, fin_st;
  logic [7:0] insn_reg, cnt, insn;
  logic [1:0] am;
  logic       mem_st, stall, br_insn;
  assign insn    = cur[I_FETCH] ? rdata : insn_reg;
  assign am      = insn[3:2];
  assign br_insn = insn[1] & insn[0];
  assign mem_st  = |cur[I_MEMLD:I_FETCH] | cur[I_MEMST];
  assign stall   = mem_st & ~mem_ready;
  // the error fires on the stall cycle that brings the count up to TIMEOUT
  assign bus_err = stall & (TIMEOUT != 0) & (cnt == TO_LAST);
  assign exec_st = insn[1] ? (insn[0] ? S_ALU : S_MEMST) : (insn[5:4] == 2'b00 ? S_MEMLD : S_ALU);
  assign fin_st  = (IRQ_EN && irq) ? S_IRQ : S_FETCH;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur      <= S_RSTV;
      insn_reg <= '0;
      cnt      <= '0;
    end else begin
      cur <= nxt;
      if (cur[I_FETCH] && mem_ready) insn_reg <= rdata;
      cnt <= (stall && !bus_err) ? cnt + 8'd1 : '0;
    end
  end
  always_comb begin
    nxt = S_RSTV;
    if (bus_err) nxt = S_FETCH;
    else if (stall) nxt = cur;
    else
      case (1'b1)
        cur[I_RSTV], cur[I_IRQ]:  nxt = S_FETCH;
        cur[I_FETCH]:             nxt = am == 2'b11 ? exec_st : S_ADDR1;
        cur[I_ADDR1]:             nxt = am == 2'b10 ? S_ADDR2 : am == 2'b01 ? S_PTR1 : exec_st;
        cur[I_ADDR2], cur[I_PTR2]: nxt = exec_st;
        cur[I_PTR1]:              nxt = S_PTR2;
        cur[I_MEMLD]:             nxt = S_ALU;
        cur[I_ALU], cur[I_MEMST]: nxt = fin_st;
        default:                  nxt = S_RSTV;
      endcase
  end
  always_comb begin
    state    = cur;
    mode     = insn[7:4];
    re       = mem_st & ~cur[I_MEMST];
    we       = cur[I_MEMST];
    pc_addr  = cur[I_FETCH] | (cur[I_MEMLD] & am == 2'b11);
    zp_addr  = cur[I_PTR1] | cur[I_PTR2] | (am == 2'b00 & ~(cur[I_RSTV] | cur[I_FETCH] | cur[I_IRQ]));
    set_al   = (cur[I_ADDR1] | cur[I_PTR2]) & mem_ready;
    set_ah   = (cur[I_ADDR2] | cur[I_PTR1]) & mem_ready;
    inc_al   = cur[I_PTR1] & mem_ready;
    reset_b  = cur[I_FETCH] & mem_ready;
    set_fr   = cur[I_ALU] & ~br_insn;
    set_a    = cur[I_ALU] & ~br_insn & ~insn[0];
    branch   = cur[I_ALU] & br_insn;
    vec_load = cur[I_RSTV] | cur[I_IRQ];
    vec_irq  = cur[I_IRQ];
    irq_ack  = cur[I_IRQ];
  end
endmodule

// File: tb/tb_faerie_cu_hs.sv
// tb_faerie_cu_hs: table-driven check of faerie_cu_hs; dut_a uses defaults, dut_b has IRQ_EN=0, TIMEOUT=3.
module tb_faerie_cu_hs;
  localparam logic [9:0] RS = 10'h001, FE = 10'h002, A1 = 10'h004, A2 = 10'h008, P1 = 10'h010;
  localparam logic [9:0] P2 = 10'h020, ML = 10'h040, AL = 10'h080, MS = 10'h100, IQ = 10'h200;
  localparam logic [14:0] VL = 15'h4000, VI = 15'h2000, IA = 15'h1000, BE = 15'h0800, RE = 15'h0400;
  localparam logic [14:0] WE = 15'h0200, PC = 15'h0100, ZP = 15'h0080, SAL = 15'h0040, SAH = 15'h0020;
  localparam logic [14:0] INC = 15'h0010, RB = 15'h0008, SFR = 15'h0004, SA = 15'h0002, BR = 15'h0001;
  typedef struct {
    bit          rst_n;
    bit          sel;
    logic [7:0]  rdata;
    bit          mr;
    bit          irq;
    logic [9:0]  st;
    logic [3:0]  mode;
    logic [14:0] s;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b1, irq = 1'b0;
  logic [7:0] rdata = '0;
  logic [3:0] mode_a, mode_b;
  logic [9:0] state_a, state_b;
  logic we_a, re_a, pc_a, zp_a, sal_a, sah_a, inc_a, rb_a, sfr_a, sa_a, br_a, vl_a, vi_a, ia_a, be_a;
  logic we_b, re_b, pc_b, zp_b, sal_b, sah_b, inc_b, rb_b, sfr_b, sa_b, br_b, vl_b, vi_b, ia_b, be_b;
  logic [28:0] obs_a, obs_b;
  int checks = 0, failures = 0;
  vec_t q[$];
  always #5 clk = ~clk;
  faerie_cu_hs dut_a (
    .clk(clk), .rst_n(rst_n), .rdata(rdata), .mem_ready(mem_ready), .irq(irq), .mode(mode_a),
    .we(we_a), .re(re_a), .pc_addr(pc_a), .zp_addr(zp_a), .set_al(sal_a), .set_ah(sah_a),
    .inc_al(inc_a), .reset_b(rb_a), .set_fr(sfr_a), .set_a(sa_a), .branch(br_a), .vec_load(vl_a),
    .vec_irq(vi_a), .irq_ack(ia_a), .bus_err(be_a), .state(state_a)
  );
  faerie_cu_hs #(.IRQ_EN(1'b0), .TIMEOUT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .rdata(rdata), .mem_ready(mem_ready), .irq(irq), .mode(mode_b),
    .we(we_b), .re(re_b), .pc_addr(pc_b), .zp_addr(zp_b), .set_al(sal_b), .set_ah(sah_b),
    .inc_al(inc_b), .reset_b(rb_b), .set_fr(sfr_b), .set_a(sa_b), .branch(br_b), .vec_load(vl_b),
    .vec_irq(vi_b), .irq_ack(ia_b), .bus_err(be_b), .state(state_b)
  );
  assign obs_a = {state_a, mode_a, vl_a, vi_a, ia_a, be_a, re_a, we_a, pc_a, zp_a, sal_a, sah_a, inc_a, rb_a, sfr_a, sa_a, br_a};
  assign obs_b = {state_b, mode_b, vl_b, vi_b, ia_b, be_b, re_b, we_b, pc_b, zp_b, sal_b, sah_b, inc_b, rb_b, sfr_b, sa_b, br_b};
  function automatic void add(bit r, bit sel, logic [7:0] d, bit mr, bit iq, logic [9:0] st, logic [3:0] m, logic [14:0] s);
    q.push_back('{r, sel, d, mr, iq, st, m, s});
  endfunction
  // drive one cycle of inputs, compare just before the next rising edge; st==0 means no compare
  task automatic apply(input vec_t v, input string name);
    logic [28:0] got, exp;
    rst_n = v.rst_n; rdata = v.rdata; mem_ready = v.mr; irq = v.irq;
    @(negedge clk);
    if (v.st != 10'd0) begin
      got = v.sel ? obs_b : obs_a;
      exp = {v.st, v.mode, v.s};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s dut_%s got state=%h mode=%h strobes=%h required state=%h mode=%h strobes=%h",
                 name, v.sel ? "b" : "a", got[28:19], got[18:15], got[14:0], exp[28:19], exp[18:15], exp[14:0]);
      end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    add(0, 0, 8'h00, 1, 0, 10'd0, 4'h0, 15'h0);
    add(0, 0, 8'h00, 1, 0, 10'd0, 4'h0, 15'h0);
    add(1, 0, 8'h88, 1, 0, RS, 4'h0, VL);
    add(1, 0, 8'h88, 1, 0, FE, 4'h8, RE | PC | RB);
    add(1, 0, 8'h34, 1, 0, A1, 4'h8, RE | SAL);
    add(1, 0, 8'h12, 1, 0, A2, 4'h8, RE | SAH);
    add(1, 0, 8'h00, 1, 0, ML, 4'h8, RE);
    add(1, 0, 8'h00, 1, 0, AL, 4'h8, SFR | SA);
    add(1, 0, 8'h04, 1, 0, FE, 4'h0, RE | PC | RB);
    add(1, 0, 8'h00, 1, 0, A1, 4'h0, RE | SAL);
    add(1, 0, 8'h00, 0, 0, P1, 4'h0, RE | ZP);
    add(1, 0, 8'h00, 0, 0, P1, 4'h0, RE | ZP);
    add(1, 0, 8'h00, 0, 0, P1, 4'h0, RE | ZP);
    add(1, 0, 8'h00, 1, 0, P1, 4'h0, RE | ZP | SAH | INC);
    add(1, 0, 8'h00, 1, 0, P2, 4'h0, RE | ZP | SAL);
    add(1, 0, 8'h00, 1, 0, ML, 4'h0, RE);
    add(1, 0, 8'h00, 1, 0, AL, 4'h0, SFR | SA);
    add(1, 0, 8'h02, 1, 1, FE, 4'h0, RE | PC | RB);
    add(1, 0, 8'h00, 1, 1, A1, 4'h0, RE | ZP | SAL);
    add(1, 0, 8'h00, 1, 1, MS, 4'h0, WE | ZP);
    add(1, 0, 8'h00, 1, 1, IQ, 4'h0, VL | VI | IA);
    add(1, 0, 8'h3C, 1, 0, FE, 4'h3, RE | PC | RB);
    add(1, 0, 8'h00, 1, 0, AL, 4'h3, SFR | SA);
    add(1, 0, 8'h0F, 1, 0, FE, 4'h0, RE | PC | RB);
    add(1, 0, 8'h00, 1, 0, AL, 4'h0, BR);
    add(1, 0, 8'h0C, 1, 0, FE, 4'h0, RE | PC | RB);
    add(1, 0, 8'h00, 1, 0, ML, 4'h0, RE | PC);
    add(1, 0, 8'h00, 1, 0, AL, 4'h0, SFR | SA);
    add(1, 0, 8'h00, 0, 0, FE, 4'h0, RE | PC);
    add(0, 1, 8'h00, 1, 0, 10'd0, 4'h0, 15'h0);
    add(0, 1, 8'h00, 1, 0, 10'd0, 4'h0, 15'h0);
    add(1, 1, 8'h08, 1, 0, RS, 4'h0, VL);
    add(1, 1, 8'h08, 1, 0, FE, 4'h0, RE | PC | RB);
    add(1, 1, 8'h00, 0, 0, A1, 4'h0, RE);
    add(1, 1, 8'h00, 0, 0, A1, 4'h0, RE);
    add(1, 1, 8'h00, 0, 0, A1, 4'h0, RE | BE);
    add(1, 1, 8'h08, 0, 0, FE, 4'h0, RE | PC);
    add(1, 1, 8'h08, 1, 0, FE, 4'h0, RE | PC | RB);
    add(1, 1, 8'h00, 0, 0, A1, 4'h0, RE);
    add(1, 1, 8'h00, 0, 0, A1, 4'h0, RE);
    add(1, 1, 8'h55, 1, 0, A1, 4'h0, RE | SAL);
    add(1, 1, 8'h66, 1, 0, A2, 4'h0, RE | SAH);
    add(1, 1, 8'h00, 1, 0, ML, 4'h0, RE);
    add(1, 1, 8'h00, 1, 1, AL, 4'h0, SFR | SA);
    add(1, 1, 8'h3C, 1, 1, FE, 4'h3, RE | PC | RB);
    add(1, 1, 8'h00, 1, 1, AL, 4'h3, SFR | SA);
    add(1, 1, 8'h00, 0, 1, FE, 4'h0, RE | PC);
    for (int i = 0; i < q.size(); i++) apply(q[i], $sformatf("row%0d", i));
    // reset in the middle of a stalled store with irq pending: lands in RSTV, then FETCH, no IRQ
    apply('{0, 0, 8'h00, 1, 0, 10'd0, 4'h0, 15'h0}, "hs_rst0");
    apply('{0, 0, 8'h00, 1, 0, 10'd0, 4'h0, 15'h0}, "hs_rst1");
    apply('{1, 0, 8'h02, 1, 0, RS, 4'h0, VL}, "hs_rstv");
    apply('{1, 0, 8'h02, 1, 0, FE, 4'h0, RE | PC | RB}, "hs_fetch");
    apply('{1, 0, 8'h00, 1, 0, A1, 4'h0, RE | ZP | SAL}, "hs_addr1");
    apply('{1, 0, 8'h00, 0, 1, MS, 4'h0, WE | ZP}, "hs_st_stall");
    apply('{0, 0, 8'h00, 0, 1, MS, 4'h0, WE | ZP}, "hs_st_rst");
    apply('{1, 0, 8'h00, 1, 1, RS, 4'h0, VL}, "hs_rstv_irq");
    apply('{1, 0, 8'h3C, 1, 1, FE, 4'h3, RE | PC | RB}, "hs_no_irq");
    apply('{1, 0, 8'h00, 1, 1, AL, 4'h3, SFR | SA}, "hs_alu");
    apply('{1, 0, 8'h00, 1, 1, IQ, 4'h3, VL | VI | IA}, "hs_irq");
    apply('{1, 0, 8'h00, 1, 0, FE, 4'h0, RE | PC | RB}, "hs_after_irq");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
